audio_dac_serializer: RTL and testbench
=======================================

Name: audio_dac_serializer

Overview:
Downstream output stage of the effect chain. It consumes 16-bit mono samples on a valid strobe from the last effect (o_data/o_valid of the delay stage) and serializes them MSB-first onto the codec DACDAT line in I2S format. The codec is bus master, so BCLK and DACLRCK arrive as asynchronous inputs that are sampled in the i_clk domain. A one-entry holding register decouples the effect pipeline from the codec frame timing; underrun and overrun are flagged.

Parameters:
DATA_W, 16, sample width and number of data bits shifted per channel slot
SYNC_STAGES, 2, flip-flop stages on i_bclk and i_daclrck, minimum 2
LEFT_LRCK, 0, DACLRCK level that denotes the left channel

Ports:
i_clk  input  1  system clock; the only clock in the block
i_rst_n  input  1  reset, synchronous, active-low
i_valid  input  1  one-cycle strobe, i_data holds a new sample
i_data  input  DATA_W  signed sample from the effect chain
i_mute  input  1  level; when 1, zeros are transmitted instead of samples
i_bclk  input  1  codec bit clock, asynchronous to i_clk
i_daclrck  input  1  codec DAC frame clock, asynchronous to i_clk
o_dacdat  output  1  serial data to the codec, registered
o_taken  output  1  one-cycle pulse when the held sample is consumed at a left-channel start
o_underrun  output  1  one-cycle pulse when a left channel starts and no sample is pending
o_overrun  output  1  one-cycle pulse when an unconsumed pending sample is overwritten
o_frame_err  output  1  one-cycle pulse when an LRCK edge arrives before all DATA_W bits are shifted

Behaviour:
- Reset: synchronous on i_rst_n=0. All outputs are 0. State is S_SYNC, pend_valid=0, the pending word is 0, the frame word is 0, the shift register is 0, and the bit counter is 0.
- Synchronizers: i_bclk and i_daclrck each pass through SYNC_STAGES flops, followed by one history flop.
  - bclk_fall means the synced value was 1 last cycle and is 0 now.
  - All serializer activity happens only in cycles where bclk_fall=1.
  - lrck_edge means that, at a bclk_fall, the synced LRCK differs from the value captured at the previous bclk_fall.
- Holding register:
  - i_valid=1 writes i_data into pend and sets pend_valid.
  - If pend_valid was already 1 and pend is not taken in the same cycle, pulse o_overrun. The newest sample always wins.
- Left-channel start (lrck_edge with the new level equal to LEFT_LRCK):
  - If pend_valid=1: frame word = pend, pend_valid is cleared, and o_taken pulses.
  - Otherwise: the frame word keeps its previous value (last sample is repeated) and o_underrun pulses.
  - If i_valid arrives in the same cycle as the take, the old pend is taken and the new sample goes into pend with pend_valid=1. No overrun is flagged.
- Right-channel start: reuses the frame word latched at the left start, so mono is duplicated. No take occurs.
- i_mute=1 at a channel start: the shift register loads 0, but the take and flag logic runs unchanged.
- FSM (all transitions occur on bclk_fall cycles only):
  - S_SYNC: o_dacdat=0. Wait for a left-channel lrck_edge, then go to S_DELAY. Right-channel edges are ignored, so output never starts mid-frame.
  - S_DELAY: the I2S one-bit delay slot; o_dacdat=0. Load the shift register and set the bit counter to DATA_W, then go to S_SHIFT on the next bclk_fall.
  - S_SHIFT: each bclk_fall drives o_dacdat = shift MSB, shifts left, and decrements the counter. When the counter reaches 0, go to S_PAD.
  - S_PAD: o_dacdat=0 until the next lrck_edge.
- lrck_edge from S_SHIFT, S_PAD or S_DELAY always goes to S_DELAY with a fresh channel start.
  - If the edge arrives while in S_SHIFT with the counter not yet 0, the remaining bits are dropped and o_frame_err pulses.
- Latency: a sample accepted at least one i_clk cycle before a left-channel start drives its MSB on the second bclk_fall after that LRCK edge. Worst case is one full frame plus SYNC_STAGES+1 i_clk cycles.
- Signedness: the word is shifted raw in two's complement, with no scaling or saturation.
- Reset mid-frame: the FSM returns to S_SYNC and resynchronizes at the next left-channel start. The pending sample is lost.

Decomposition:
- Shared package audio_pkg holds:
  - the state enum with S_SYNC, S_DELAY, S_SHIFT, S_PAD
  - the DATA_W default
  - the LEFT_LRCK constant
- One sub-module, sync_edge_det: a SYNC_STAGES synchronizer plus history flop, emitting synced level, rise and fall. It is instantiated twice: for bclk_fall, and for the LRCK level sampled at bclk_fall.

Test Plan:
- Bench timing for all scenarios: bclk period 16 i_clk cycles, 32 bclk per channel.
- Basic frame: i_valid with 16'h8001 before a left LRCK edge -> o_taken pulses once; DACDAT shows a 0 delay bit, then 1000_0000_0000_0001, then zeros; the right slot repeats the same 16 bits.
- Startup alignment: release reset while LRCK is at the right level -> o_dacdat stays 0 with no o_taken until the first left edge; the first transmitted word is the pending sample.
- Underrun: no i_valid for two frames after 16'h1234 -> o_underrun pulses at both left starts, and 16'h1234 is retransmitted in all four slots.
- Overrun and same-cycle take: i_valid 16'hAAAA then 16'h5555 before a left start -> one o_overrun, and 16'h5555 is sent. Then i_valid 16'h0F0F exactly on the take cycle -> no o_overrun; 16'h0F0F is sent in the following frame.
- Short frame: LRCK toggles after 10 bclk -> o_frame_err pulses, the remaining 6 bits are not sent, and the next slot starts with a 0 delay bit then the MSB.
- Mute and mid-frame reset: i_mute=1 with 16'hFFFF -> all-zero DACDAT while o_taken still pulses. Reset during S_SHIFT -> outputs 0 on the next cycle and the block resynchronizes at the next left edge.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and defaults for the codec DAC output stage.
// Imported by the serializer top and its handshake interface.
package audio_pkg;

    localparam int   DATA_W_DEF = 16;
    localparam logic LEFT_LRCK  = 1'b0;

    typedef enum logic [1:0] {
        S_SYNC,
        S_DELAY,
        S_SHIFT,
        S_PAD
    } state_e;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample-side strobe, codec pins and status pulses of the DAC serializer.
// The master drives samples and codec clocks; the slave is the serializer.
interface audio_dac_serializer_if
    import audio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_mute;
    logic              i_bclk;
    logic              i_daclrck;
    logic              o_dacdat;
    logic              o_taken;
    logic              o_underrun;
    logic              o_overrun;
    logic              o_frame_err;

    modport master (
        output i_valid,
        output i_data,
        output i_mute,
        output i_bclk,
        output i_daclrck,
        input  o_dacdat,
        input  o_taken,
        input  o_underrun,
        input  o_overrun,
        input  o_frame_err
    );

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_mute,
        input  i_bclk,
        input  i_daclrck,
        output o_dacdat,
        output o_taken,
        output o_underrun,
        output o_overrun,
        output o_frame_err
    );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer plus an enable-gated history flop.
// Edges are reported only in cycles where i_en is high.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
            if (i_en) begin
                hist_q <= sync_q[STAGES-1];
            end
        end
    end

    assign o_level = sync_q[STAGES-1];
    assign o_rise  = i_en & o_level & ~hist_q;
    assign o_fall  = i_en & ~o_level & hist_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: one-entry sample holding register feeding a
// codec-clocked MSB-first shifter, mono duplicated into both slots.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int   DATA_W      = DATA_W_DEF,
    parameter int   SYNC_STAGES = 2,
    parameter logic LEFT_LRCK   = audio_pkg::LEFT_LRCK
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    audio_dac_serializer_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic bclk_lvl;
    logic bclk_rise;
    logic bclk_fall;
    logic lrck_lvl;
    logic lrck_rise;
    logic lrck_fall;
    logic unused_bclk;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_bclk_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (1'b1),
        .i_d     (bus.i_bclk),
        .o_level (bclk_lvl),
        .o_rise  (bclk_rise),
        .o_fall  (bclk_fall)
    );

    // LRCK history only advances on bit-clock falls
    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_lrck_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (bclk_fall),
        .i_d     (bus.i_daclrck),
        .o_level (lrck_lvl),
        .o_rise  (lrck_rise),
        .o_fall  (lrck_fall)
    );

    assign unused_bclk = ^{bclk_lvl, bclk_rise};

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] pend_q;
    logic              pend_vld_q;
    logic [DATA_W-1:0] frame_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              dacdat_q;
    logic              taken_q;
    logic              underrun_q;
    logic              overrun_q;
    logic              frame_err_q;

    logic              lrck_edge;
    logic              left_start;
    logic              take;
    logic              load;
    logic              shift_en;
    logic              ferr;
    logic [DATA_W-1:0] word;

    assign lrck_edge  = lrck_rise | lrck_fall;
    assign left_start = lrck_edge & (lrck_lvl == LEFT_LRCK);
    assign take       = left_start & pend_vld_q;
    assign word       = take ? pend_q : frame_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        ferr     = 1'b0;
        if (bclk_fall) begin
            unique case (state_q)
                S_SYNC: begin
                    if (left_start) begin
                        state_d = S_DELAY;
                        load    = 1'b1;
                    end
                end
                S_DELAY: begin
                    if (lrck_edge) begin
                        load     = 1'b1;
                    end else begin
                        state_d  = S_SHIFT;
                        shift_en = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (lrck_edge) begin
                        state_d = S_DELAY;
                        load    = 1'b1;
                        ferr    = (cnt_q != '0);
                    end else begin
                        shift_en = 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    if (lrck_edge) begin
                        state_d = S_DELAY;
                        load    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            frame_q     <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            dacdat_q    <= 1'b0;
            taken_q     <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            taken_q     <= take;
            underrun_q  <= left_start & ~pend_vld_q;
            overrun_q   <= bus.i_valid & pend_vld_q & ~take;
            frame_err_q <= ferr;
            // a same-cycle write refills pend after the old word is taken
            if (bus.i_valid) begin
                pend_q     <= bus.i_data;
                pend_vld_q <= 1'b1;
            end else if (take) begin
                pend_vld_q <= 1'b0;
            end
            if (take) begin
                frame_q <= pend_q;
            end
            if (load) begin
                shift_q  <= bus.i_mute ? '0 : word;
                cnt_q    <= CNT_W'(DATA_W);
                dacdat_q <= 1'b0;
            end else if (shift_en) begin
                dacdat_q <= shift_q[DATA_W-1];
                shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
                cnt_q    <= cnt_q - CNT_W'(1);
            end else if (bclk_fall) begin
                dacdat_q <= 1'b0;
            end
        end
    end

    assign bus.o_dacdat    = dacdat_q;
    assign bus.o_taken     = taken_q;
    assign bus.o_underrun  = underrun_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for the I2S DAC serializer: drives codec clocks, queues expected
// slot contents and compares each captured DACDAT slot against them.
module tb_audio_dac_serializer;

    localparam int SYNC = 2;

    typedef struct {
        bit          on;
        logic [15:0] word;
    } slot_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    slot_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    c_taken = 0;
    int    c_under = 0;
    int    c_over = 0;
    int    c_ferr = 0;

    audio_dac_serializer_if #(.DATA_W(16)) bus ();

    audio_dac_serializer #(
        .DATA_W      (16),
        .SYNC_STAGES (SYNC),
        .LEFT_LRCK   (1'b0)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_taken)     c_taken <= c_taken + 1;
        if (bus.o_underrun)  c_under <= c_under + 1;
        if (bus.o_overrun)   c_over  <= c_over + 1;
        if (bus.o_frame_err) c_ferr  <= c_ferr + 1;
    end

    task automatic push_exp(input bit on, input logic [15:0] w);
        slot_t s;
        s.on   = on;
        s.word = w;
        exp_q.push_back(s);
    endtask

    task automatic push_sample(input logic [15:0] d);
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // one channel slot of nb bit clocks; DACDAT captured at each rise
    task automatic run_slot(input logic lvl, input int nb,
                            input bit inj, input logic [15:0] d);
        slot_t       e;
        logic [63:0] got;
        logic [63:0] want;
        logic        b;
        got  = '0;
        want = '0;
        for (int k = 0; k < nb; k++) begin
            bus.i_bclk = 1'b0;
            if (k == 0) bus.i_daclrck = lvl;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                bus.i_valid = inj && (k == 0) && (c == SYNC);
                if (bus.i_valid) bus.i_data = d;
            end
            got = {got[62:0], bus.o_dacdat};
            bus.i_bclk = 1'b1;
            repeat (8) @(negedge clk);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL slot: no expected entry queued");
        end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < nb; k++) begin
                b = 1'b0;
                if (e.on && k >= 1 && k <= 16) b = e.word[16-k];
                want = {want[62:0], b};
            end
            if (got !== want) begin
                n_err++;
                $display("FAIL slot lrck=%0b: got %h expected %h",
                         lvl, got, want);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data = '0;
        bus.i_mute = 1'b0;
        bus.i_bclk = 1'b1;
        bus.i_daclrck = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({bus.o_dacdat, bus.o_taken, bus.o_underrun,
             bus.o_overrun, bus.o_frame_err} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {bus.o_dacdat, bus.o_taken, bus.o_underrun,
                      bus.o_overrun, bus.o_frame_err});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_startup();
        int t0 = c_taken;
        push_sample(16'h8001);
        push_exp(1'b0, 16'h0);
        run_slot(1'b1, 32, 1'b0, 16'h0);
        n_vec++;
        if (c_taken - t0 !== 0) begin
            n_err++;
            $display("FAIL startup_taken: got %0d expected 0", c_taken - t0);
        end
    endtask

    task automatic test_basic();
        int t0 = c_taken;
        int u0 = c_under;
        push_exp(1'b1, 16'h8001);
        run_slot(1'b0, 32, 1'b0, 16'h0);
        push_exp(1'b1, 16'h8001);
        run_slot(1'b1, 32, 1'b0, 16'h0);
        n_vec++;
        if (c_taken - t0 !== 1 || c_under - u0 !== 0) begin
            n_err++;
            $display("FAIL basic_flags: taken %0d underrun %0d expected 1 0",
                     c_taken - t0, c_under - u0);
        end
    endtask

    task automatic test_underrun();
        int t0 = c_taken;
        int u0 = c_under;
        push_sample(16'h1234);
        for (int f = 0; f < 3; f++) begin
            push_exp(1'b1, 16'h1234);
            run_slot(1'b0, 32, 1'b0, 16'h0);
            push_exp(1'b1, 16'h1234);
            run_slot(1'b1, 32, 1'b0, 16'h0);
        end
        n_vec++;
        if (c_taken - t0 !== 1 || c_under - u0 !== 2) begin
            n_err++;
            $display("FAIL underrun_flags: taken %0d underrun %0d expected 1 2",
                     c_taken - t0, c_under - u0);
        end
    endtask

    task automatic test_overrun();
        int t0 = c_taken;
        int o0 = c_over;
        push_sample(16'hAAAA);
        push_sample(16'h5555);
        repeat (2) @(negedge clk);
        n_vec++;
        if (c_over - o0 !== 1) begin
            n_err++;
            $display("FAIL overrun_pulse: got %0d expected 1", c_over - o0);
        end
        push_exp(1'b1, 16'h5555);
        run_slot(1'b0, 32, 1'b1, 16'h0F0F);
        push_exp(1'b1, 16'h5555);
        run_slot(1'b1, 32, 1'b0, 16'h0);
        push_exp(1'b1, 16'h0F0F);
        run_slot(1'b0, 32, 1'b0, 16'h0);
        push_exp(1'b1, 16'h0F0F);
        run_slot(1'b1, 32, 1'b0, 16'h0);
        n_vec++;
        if (c_over - o0 !== 1 || c_taken - t0 !== 2) begin
            n_err++;
            $display("FAIL same_cycle_take: overrun %0d taken %0d expected 1 2",
                     c_over - o0, c_taken - t0);
        end
    endtask

    task automatic test_short_frame();
        int f0 = c_ferr;
        push_sample(16'hC3A5);
        push_exp(1'b1, 16'hC3A5);
        run_slot(1'b0, 11, 1'b0, 16'h0);
        push_exp(1'b1, 16'hC3A5);
        run_slot(1'b1, 32, 1'b0, 16'h0);
        n_vec++;
        if (c_ferr - f0 !== 1) begin
            n_err++;
            $display("FAIL frame_err: got %0d expected 1", c_ferr - f0);
        end
    endtask

    task automatic test_mute();
        int t0 = c_taken;
        bus.i_mute = 1'b1;
        push_sample(16'hFFFF);
        push_exp(1'b1, 16'h0000);
        run_slot(1'b0, 32, 1'b0, 16'h0);
        push_exp(1'b1, 16'h0000);
        run_slot(1'b1, 32, 1'b0, 16'h0);
        bus.i_mute = 1'b0;
        n_vec++;
        if (c_taken - t0 !== 1) begin
            n_err++;
            $display("FAIL mute_taken: got %0d expected 1", c_taken - t0);
        end
    endtask

    task automatic test_mid_reset();
        int t0;
        int u0;
        push_sample(16'hF0F0);
        for (int k = 0; k < 3; k++) begin
            bus.i_bclk = 1'b0;
            if (k == 0) bus.i_daclrck = 1'b0;
            repeat (8) @(negedge clk);
            bus.i_bclk = 1'b1;
            repeat (8) @(negedge clk);
        end
        push_sample(16'h1111);
        n_vec++;
        if (bus.o_dacdat !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_bit: got %b expected 1", bus.o_dacdat);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.o_dacdat, bus.o_taken, bus.o_underrun,
             bus.o_overrun, bus.o_frame_err} !== 5'b0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %b expected 00000",
                     {bus.o_dacdat, bus.o_taken, bus.o_underrun,
                      bus.o_overrun, bus.o_frame_err});
        end
        rst_n = 1'b1;
        for (int k = 3; k < 32; k++) begin
            bus.i_bclk = 1'b0;
            repeat (8) @(negedge clk);
            bus.i_bclk = 1'b1;
            repeat (8) @(negedge clk);
        end
        t0 = c_taken;
        u0 = c_under;
        push_exp(1'b0, 16'h0);
        run_slot(1'b1, 32, 1'b0, 16'h0);
        push_exp(1'b1, 16'h0000);
        run_slot(1'b0, 32, 1'b0, 16'h0);
        push_exp(1'b1, 16'h0000);
        run_slot(1'b1, 32, 1'b0, 16'h0);
        push_sample(16'h2468);
        push_exp(1'b1, 16'h2468);
        run_slot(1'b0, 32, 1'b0, 16'h0);
        push_exp(1'b1, 16'h2468);
        run_slot(1'b1, 32, 1'b0, 16'h0);
        n_vec++;
        if (c_taken - t0 !== 1 || c_under - u0 !== 1) begin
            n_err++;
            $display("FAIL resync_flags: taken %0d underrun %0d expected 1 1",
                     c_taken - t0, c_under - u0);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_basic();
        test_underrun();
        test_overrun();
        test_short_frame();
        test_mute();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
